// File: rtl/pcs_code_group_tx.sv
// 1000BASE-X PCS transmit code-group generator with 8B/10B encoding.
// Define TX_CG_PIPE_EN to add one extra output register stage.
module pcs_code_group_tx (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic [2:0] tx_o_set,
  input  logic [7:0] TXD,
  output logic [9:0] tx_code_group,
  output logic       tx_even,
  output logic       TX_OSET_indicate,
  output logic       tx_disparity
);

  typedef enum logic [1:0] {
    GENERATE_CODE_GROUPS,
    IDLE_I2B,
    SPECIAL_GO,
    DATA_GO
  } state_t;

  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D5_6  = 8'hC5;

  state_t     state_q, state_d;
  logic [9:0] cg_q, cg_d;
  logic       even_q, even_d;
  logic       ind_q, ind_d;
  logic       rd_q, rd_d;
  logic       samp, is_idle, is_data;
  logic [7:0] byte_sel;
  logic [10:0] enc;
  logic [9:0] k_cg;

  function automatic logic [5:0] enc6(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;
      5'd1:  c = 6'b011101;
      5'd2:  c = 6'b101101;
      5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;
      5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;
      5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;
      5'd9:  c = 6'b100101;
      5'd10: c = 6'b010101;
      5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;
      5'd13: c = 6'b101100;
      5'd14: c = 6'b011100;
      5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;
      5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;
      5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;
      5'd21: c = 6'b101010;
      5'd22: c = 6'b011010;
      5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;
      5'd25: c = 6'b100110;
      5'd26: c = 6'b010110;
      5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;
      5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] enc4(input logic [2:0] y, input logic a7);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;
      3'd1: c = 4'b1001;
      3'd2: c = 4'b0101;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = 4'b1010;
      3'd6: c = 4'b0110;
      default: c = a7 ? 4'b0111 : 4'b1110;
    endcase
    return c;
  endfunction

  // Tables hold the RD- column; RD+ is the complement for unbalanced codes.
  function automatic logic [10:0] enc8b10b(input logic [7:0] d, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic bal6, bal4, rd1, rd2, a7;
    x = d[4:0];
    y = d[7:5];
    c6 = enc6(x);
    bal6 = ($countones(c6) == 3);
    if (rd && (!bal6 || x == 5'd7)) c6 = ~c6;
    rd1 = bal6 ? rd : ~rd;
    a7 = (!rd1 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
         (rd1 && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    c4 = enc4(y, a7);
    bal4 = ($countones(c4) == 2);
    if (rd1 && (!bal4 || y == 3'd3)) c4 = ~c4;
    rd2 = bal4 ? rd1 : ~rd1;
    return {rd2, c6, c4};
  endfunction

  assign samp    = (state_q != IDLE_I2B);
  assign is_idle = (tx_o_set == 3'b000);
  assign is_data = (tx_o_set == 3'b101);

  always_comb begin
    state_d = GENERATE_CODE_GROUPS;
    if (samp) begin
      unique case (1'b1)
        is_idle: state_d = even_q ? GENERATE_CODE_GROUPS : IDLE_I2B;
        is_data: state_d = DATA_GO;
        default: state_d = SPECIAL_GO;
      endcase
    end
  end

  // In IDLE_I2B, rd_q is RD after K28.5, i.e. the inverse of RD before it.
  always_comb begin
    byte_sel = TXD;
    if (state_q == IDLE_I2B) byte_sel = rd_q ? D16_2 : D5_6;
    else if (is_idle) byte_sel = D16_2;
  end

  assign enc = enc8b10b(byte_sel, rd_q);

  always_comb begin
    case (tx_o_set)
      3'b001:  k_cg = rd_q ? 10'h097 : 10'h368;
      3'b010:  k_cg = rd_q ? 10'h117 : 10'h2E8;
      3'b011:  k_cg = rd_q ? 10'h057 : 10'h3A8;
      default: k_cg = rd_q ? 10'h217 : 10'h1E8;
    endcase
  end

  always_comb begin
    cg_d   = enc[9:0];
    rd_d   = enc[10];
    ind_d  = 1'b1;
    even_d = ~even_q;
    unique case (state_d)
      IDLE_I2B: begin
        cg_d  = rd_q ? 10'h305 : 10'h0FA;
        rd_d  = ~rd_q;
        ind_d = 1'b0;
      end
      SPECIAL_GO: begin
        cg_d = k_cg;
        rd_d = rd_q;
      end
      DATA_GO: ind_d = 1'b1;
      GENERATE_CODE_GROUPS: ind_d = (state_q == IDLE_I2B);
    endcase
  end

  always_ff @(posedge GTX_CLK) begin
    if (!mr_main_reset) begin
      state_q <= GENERATE_CODE_GROUPS;
      cg_q    <= 10'h0FA;
      even_q  <= 1'b0;
      ind_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cg_q    <= cg_d;
      even_q  <= even_d;
      ind_q   <= ind_d;
      rd_q    <= rd_d;
    end
  end

`ifdef TX_CG_PIPE_EN
  logic [9:0] cg_p_q;
  logic       even_p_q, ind_p_q, rd_p_q;

  always_ff @(posedge GTX_CLK) begin
    if (!mr_main_reset) begin
      cg_p_q   <= 10'h0FA;
      even_p_q <= 1'b0;
      ind_p_q  <= 1'b0;
      rd_p_q   <= 1'b0;
    end else begin
      cg_p_q   <= cg_q;
      even_p_q <= even_q;
      ind_p_q  <= ind_q;
      rd_p_q   <= rd_q;
    end
  end

  assign tx_code_group    = cg_p_q;
  assign tx_even          = even_p_q;
  assign TX_OSET_indicate = ind_p_q;
  assign tx_disparity     = rd_p_q;
`else
  assign tx_code_group    = cg_q;
  assign tx_even          = even_q;
  assign TX_OSET_indicate = ind_q;
  assign tx_disparity     = rd_q;
`endif

endmodule

// File: tb/tb_pcs_code_group_tx.sv
// Scoreboard bench for pcs_code_group_tx: directed ordered-set vectors
// with hand-computed code groups; latency follows TX_CG_PIPE_EN.
module tb_pcs_code_group_tx;

`ifdef TX_CG_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [2:0] OI = 3'b000;
  localparam logic [2:0] OS = 3'b001;
  localparam logic [2:0] OT = 3'b010;
  localparam logic [2:0] OR = 3'b011;
  localparam logic [2:0] OV = 3'b100;
  localparam logic [2:0] OD = 3'b101;

  logic       clk;
  logic       mr_main_reset;
  logic [2:0] tx_o_set;
  logic [7:0] TXD;
  logic [9:0] tx_code_group;
  logic       tx_even;
  logic       TX_OSET_indicate;
  logic       tx_disparity;

  pcs_code_group_tx dut (
    .GTX_CLK          (clk),
    .mr_main_reset    (mr_main_reset),
    .tx_o_set         (tx_o_set),
    .TXD              (TXD),
    .tx_code_group    (tx_code_group),
    .tx_even          (tx_even),
    .TX_OSET_indicate (TX_OSET_indicate),
    .tx_disparity     (tx_disparity)
  );

  typedef struct {
    logic       rst;
    logic [2:0] set;
    logic [7:0] txd;
    logic [9:0] cg;
    logic       ev;
    logic       ind;
    logic       rd;
  } vec_t;

  typedef struct {
    int         tgt;
    int         row;
    logic [9:0] cg;
    logic       ev;
    logic       ind;
    logic       rd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic add(input logic rst, input logic [2:0] s,
                     input logic [7:0] d, input logic [9:0] cg,
                     input logic ev, input logic ind, input logic rd);
    vec_t v;
    v.rst = rst;
    v.set = s;
    v.txd = d;
    v.cg  = cg;
    v.ev  = ev;
    v.ind = ind;
    v.rd  = rd;
    vecs.push_back(v);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tgt < cyc) begin
      checks++;
      failures++;
      $display("FAIL row%0d missed: no output observed at cycle %0d",
               sb[0].row, sb[0].tgt);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].tgt == cyc) begin
      checks++;
      if (tx_code_group !== sb[0].cg || tx_even !== sb[0].ev ||
          TX_OSET_indicate !== sb[0].ind || tx_disparity !== sb[0].rd) begin
        failures++;
        $display("FAIL row%0d got cg=%h ev=%b ind=%b rd=%b expected cg=%h ev=%b ind=%b rd=%b",
                 sb[0].row, tx_code_group, tx_even, TX_OSET_indicate,
                 tx_disparity, sb[0].cg, sb[0].ev, sb[0].ind, sb[0].rd);
      end
      void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic skip;
    // reset
    add(1, OI, 8'h00, 10'h0FA, 0, 0, 0);
    add(1, OI, 8'h00, 10'h0FA, 0, 0, 0);
    // steady idle from RD-
    add(0, OI, 8'h00, 10'h0FA, 1, 0, 1);
    add(0, OI, 8'h00, 10'h245, 0, 1, 0);
    add(0, OI, 8'h00, 10'h0FA, 1, 0, 1);
    add(0, OI, 8'h00, 10'h245, 0, 1, 0);
    // D0.0, D0.1 leave RD+, then /I1/
    add(0, OD, 8'h00, 10'h274, 1, 1, 0);
    add(0, OD, 8'h20, 10'h279, 0, 1, 1);
    add(0, OI, 8'h00, 10'h305, 1, 0, 0);
    add(0, OI, 8'h00, 10'h296, 0, 1, 0);
    // S D T R I from RD-
    add(0, OS, 8'h00, 10'h368, 1, 1, 0);
    add(0, OD, 8'h00, 10'h274, 0, 1, 0);
    add(0, OT, 8'h00, 10'h2E8, 1, 1, 0);
    add(0, OR, 8'h00, 10'h3A8, 0, 1, 0);
    add(0, OI, 8'h00, 10'h0FA, 1, 0, 1);
    add(0, OI, 8'h00, 10'h245, 0, 1, 0);
    // V then /I/ in odd slot: filler first
    add(0, OV, 8'h00, 10'h1E8, 1, 1, 0);
    add(0, OI, 8'h00, 10'h1B5, 0, 0, 1);
    add(0, OI, 8'h00, 10'h305, 1, 0, 0);
    add(0, OI, 8'h00, 10'h296, 0, 1, 0);
    // illegal codes act as /V/
    add(0, 3'b111, 8'h00, 10'h1E8, 1, 1, 0);
    add(0, 3'b110, 8'h00, 10'h1E8, 0, 1, 0);
    // RD+ specials, P7/A7, D7.3 from RD+
    add(0, OD, 8'h20, 10'h279, 1, 1, 1);
    add(0, OS, 8'h00, 10'h097, 0, 1, 1);
    add(0, OD, 8'hFF, 10'h14E, 1, 1, 1);
    add(0, OD, 8'hEB, 10'h348, 0, 1, 0);
    add(0, OD, 8'hF1, 10'h237, 1, 1, 1);
    add(0, OD, 8'h00, 10'h18B, 0, 1, 1);
    add(0, OD, 8'h67, 10'h073, 1, 1, 1);
    add(0, OV, 8'h00, 10'h217, 0, 1, 1);
    // reset during IDLE_I2B
    add(0, OI, 8'h00, 10'h305, 1, 0, 0);
    add(1, OI, 8'h00, 10'h0FA, 0, 0, 0);
    add(0, OI, 8'h00, 10'h0FA, 1, 0, 1);
    add(0, OI, 8'h00, 10'h245, 0, 1, 0);
    add(0, OT, 8'h00, 10'h2E8, 1, 1, 0);
    add(0, OI, 8'h00, 10'h1B5, 0, 0, 1);
    add(0, OI, 8'h00, 10'h305, 1, 0, 0);
    add(0, OI, 8'h00, 10'h296, 0, 1, 0);
    add(0, OI, 8'h00, 10'h0FA, 1, 0, 1);
    add(0, OI, 8'h00, 10'h245, 0, 1, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      mr_main_reset = ~vecs[k].rst;
      tx_o_set      = vecs[k].set;
      TXD           = vecs[k].txd;
      // with the extra stage, a reset on the next edge clears this result
      skip = (LAT == 2) && !vecs[k].rst && (k + 1 < vecs.size()) &&
             vecs[k + 1].rst;
      if (!skip) begin
        e.tgt = cyc + LAT;
        e.row = k;
        e.cg  = vecs[k].cg;
        e.ev  = vecs[k].ev;
        e.ind = vecs[k].ind;
        e.rd  = vecs[k].rd;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    mr_main_reset = 1'b1;
    tx_o_set      = OI;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected outputs left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcs_code_group_tx.md
PCS_CODE_GROUP_TX -- requirements
Module: pcs_code_group_tx

Interface
REQ-001 SHALL provide: GTX_CLK  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL provide: mr_main_reset  in  1  synchronous, active-low reset.
REQ-003 SHALL provide: tx_o_set  in  3  ordered-set request from the upstream ordered-set machine: 000 /I/, 001 /S/, 010 /T/, 011 /R/, 100 /V/, 101 /D/; 110 and 111 are illegal.
REQ-004 SHALL provide: TXD  in  8  data octet, sampled only when tx_o_set=/D/.
REQ-005 SHALL provide: tx_code_group  out  10  encoded code group; bit 9 = a (transmitted first), bit 0 = j.
REQ-006 SHALL provide: tx_even  out  1  high when the current tx_code_group occupies an even slot.
REQ-007 SHALL provide: TX_OSET_indicate  out  1  one-cycle pulse when the current ordered set completes; upstream presents the next set on the following cycle.
REQ-008 SHALL provide: tx_disparity  out  1  running disparity after the current code group, 0 = RD-, 1 = RD+.

Function
REQ-009 SHALL implement a state machine with states GENERATE_CODE_GROUPS, IDLE_I2B, SPECIAL_GO and DATA_GO.
REQ-010 SHALL sample tx_o_set and TXD in GENERATE_CODE_GROUPS only, and also in the cycle following a TX_OSET_indicate pulse; the inputs are ignored at all other times.
REQ-011 /I/: SHALL output K28.5 in an even slot, go to IDLE_I2B, then output D5.6 (/I1/) if the RD before K28.5 was RD+, or D16.2 (/I2/) if it was RD-; TX_OSET_indicate SHALL pulse on the second code group.
REQ-012 If /I/ is requested in an odd slot, the block SHALL first output one K28.5-free filler D16.2 so that K28.5 lands in an even slot; this cycle SHALL NOT pulse TX_OSET_indicate.
REQ-013 /S/, /T/, /R/ and /V/ SHALL map to K27.7, K29.7, K23.7 and K30.7 (SPECIAL_GO), one code group each, and SHALL pulse TX_OSET_indicate.
REQ-014 /D/ SHALL encode TXD as Dx.y in DATA_GO per 8B/10B (5b/6b then 3b/4b, with the alternate A7 for x.7 per the standard), and SHALL pulse TX_OSET_indicate.
REQ-015 Illegal tx_o_set (110 or 111) SHALL be treated as /V/.
REQ-016 Running disparity SHALL update after each sub-block per 8B/10B rules; the RD- or RD+ column SHALL be chosen from the disparity entering that sub-block.
REQ-017 tx_even SHALL toggle every cycle.
REQ-018 Latency from sampling a request to the corresponding tx_code_group SHALL be one GTX_CLK cycle, with the output registered.

Reset
REQ-019 While mr_main_reset=0 at a clock edge, the block SHALL enter GENERATE_CODE_GROUPS and set tx_disparity=0, tx_even=0, TX_OSET_indicate=0 and tx_code_group=10'h0FA (K28.5 RD-).
REQ-020 On the first edge after reset release, the block SHALL set tx_even=1; the reset state means the next slot is even.
REQ-021 Reset asserted mid-ordered-set (including during IDLE_I2B) SHALL abandon that set; no TX_OSET_indicate pulse SHALL be issued for it.

Configuration
REQ-022 With macro TX_CG_PIPE_EN defined, the block SHALL add one further register on tx_code_group, tx_even, TX_OSET_indicate and tx_disparity; all four are delayed together, latency becomes 2 cycles, and this register also resets to the values in REQ-019.
REQ-023 Without TX_CG_PIPE_EN, latency SHALL be 1 cycle per REQ-018.

Verification
REQ-024 Reset, release, then hold tx_o_set=/I/ -> output 0x0FA (K28.5 RD-, tx_even=1), then 0x245 (D16.2 RD+, tx_even=0, indicate=1), repeating with tx_disparity=0 at each set end.
REQ-025 Force RD+ entry (send D0.0=0x274 and one more byte ending RD+), then /I/ -> K28.5 RD+ 0x305 followed by D5.6 0x296.
REQ-026 /S/, /D/ TXD=00, /T/, /R/, /I/ from RD- -> 0x368, 0x274, K29.7, K23.7, K28.5, each with indicate=1 for single-code-group sets.
REQ-027 Request /I/ in an odd slot -> one D16.2 filler with indicate=0, then K28.5 with tx_even=1.
REQ-028 tx_o_set=3'b111 -> K30.7 (0x1E8 from RD-) with indicate=1.
REQ-029 Reset asserted during IDLE_I2B -> next output 0x0FA with no indicate; repeat REQ-024 with TX_CG_PIPE_EN defined and confirm every response is shifted by one cycle.
